// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// Scoreboard rd fields are zero-extended to RD_MAX_W bits.
package pipe_pkg;

  localparam int RD_MAX_W = 8;
  localparam int FWD_NONE = 0;
  localparam logic [RD_MAX_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } sb_entry_t;

endpackage

// File: rtl/hazard_fwd_match.sv
// Single-operand forwarding matcher over the downstream
// scoreboard entries; the youngest matching producer wins.
module hazard_fwd_match
  import pipe_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int FSW       = $clog2(FWD_DEPTH+1)
) (
  input  logic [RD_MAX_W-1:0]     rs,
  input  logic                    rs_used,
  input  sb_entry_t [FWD_DEPTH:1] sb,
  output logic [FSW-1:0]          sel
);

  always_comb begin
    sel = FSW'(FWD_NONE);
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (rs_used && rs != REG_ZERO &&
          sb[k].valid && sb[k].regwrite &&
          sb[k].rd == rs)
        sel = FSW'(k);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding / load-use / branch-flush controller.
// HAZARD_PERF_CNT_EN adds saturating stall and flush counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FSW       = $clog2(FWD_DEPTH+1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_memread_i,
  input  logic                      ex_branch_taken_i,
  output logic                      stall_o,
  output logic                      if_flush_o,
  output logic                      id_flush_o,
  output logic [NUM_SRC*FSW-1:0]    ex_fwd_sel_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               flush_cnt_o
`endif
);

  sb_entry_t [FWD_DEPTH:0]   sb;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [NUM_SRC-1:0]        ex_rs_used;
  logic                      load_use;
  logic                      ex_load;

  // Producer load whose data is not forwardable when ID reaches EX.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < LOAD_LAT; k++) begin
        if (id_valid_i && id_rs_used_i[i] &&
            sb[k].valid && sb[k].memread &&
            sb[k].rd != REG_ZERO &&
            sb[k].rd == RD_MAX_W'(id_rs_i[i*REG_AW +: REG_AW]))
          load_use = 1'b1;
      end
    end
  end

  assign stall_o    = load_use & ~ex_branch_taken_i;
  assign if_flush_o = rst_i & ex_branch_taken_i;
  assign id_flush_o = rst_i & (ex_branch_taken_i | load_use);
  assign ex_load    = id_valid_i & ~id_flush_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sb         <= '0;
      ex_rs      <= '0;
      ex_rs_used <= '0;
    end else begin
      sb[FWD_DEPTH:1] <= sb[FWD_DEPTH-1:0];
      sb[0].valid     <= ex_load;
      sb[0].rd        <= ex_load ? RD_MAX_W'(id_rd_i)
                                 : REG_ZERO;
      sb[0].regwrite  <= ex_load & id_regwrite_i;
      sb[0].memread   <= ex_load & id_memread_i;
      ex_rs           <= ex_load ? id_rs_i : '0;
      ex_rs_used      <= ex_load ? id_rs_used_i : '0;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    hazard_fwd_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .FSW       (FSW)
    ) u_match (
      .rs      (RD_MAX_W'(ex_rs[i*REG_AW +: REG_AW])),
      .rs_used (ex_rs_used[i]),
      .sb      (sb[FWD_DEPTH:1]),
      .sel     (ex_fwd_sel_o[i*FSW +: FSW])
    );
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (if_flush_o && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule
